// File: rtl/bsw_debounce_pkg.sv
// Shared constants for the buttons/switches input conditioning block.
package bsw_debounce_pkg;

    localparam int DEF_PRESCALE = 50000;   // 1 ms sampling tick at 50 MHz
    localparam int DEF_STABLE   = 8;

    localparam logic KEY_IDLE = 1'b1;      // buttons are active-low
    localparam logic SW_IDLE  = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced input bit: two-flop synchroniser plus tick-based stability counter.
module debounce_chan
    import bsw_debounce_pkg::*;
#(
    parameter int   STABLE = DEF_STABLE,
    parameter logic IDLE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic out
);

    localparam int             CW      = cnt_width(STABLE);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE - 1);

    logic          meta_p0;
    logic          samp;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_p0 <= IDLE;
            samp    <= IDLE;
            out     <= IDLE;
            cnt     <= '0;
        end else begin
            meta_p0 <= raw;
            samp    <= meta_p0;
            // Any return to the accepted level throws away accumulated credit.
            if (samp == out) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_MAX) begin
                    out <= samp;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bsw_debounce.sv
// Debounce front end for board buttons and switches: shared prescaler plus per-bit channels.
module bsw_debounce
    import bsw_debounce_pkg::*;
#(
    parameter int NKEYS    = 4,
    parameter int NSW      = 8,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int STABLE   = DEF_STABLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] keys_raw_n,
    input  logic [NSW-1:0]   sw_raw,
    output logic [NKEYS-1:0] keys_n,
    output logic [NSW-1:0]   sw,
    output logic             tick
);

    localparam int            PW       = cnt_width(PRESCALE);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    assign tick = (pcnt == PCNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        debounce_chan #(.STABLE(STABLE), .IDLE(KEY_IDLE)) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .raw  (keys_raw_n[i]),
            .out  (keys_n[i])
        );
    end

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        debounce_chan #(.STABLE(STABLE), .IDLE(SW_IDLE)) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .raw  (sw_raw[i]),
            .out  (sw[i])
        );
    end

endmodule

// File: tb/tb_bsw_debounce.sv
// Bench for bsw_debounce: directed scenarios plus random bouncing against a tick-arithmetic model.
module tb_bsw_debounce;

    localparam int NK  = 4;
    localparam int NS  = 8;
    localparam int P   = 4;
    localparam int S   = 3;
    localparam int NCH = NK + NS;
    localparam logic [NCH-1:0] IDLE_V = {8'h00, 4'hF};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] keys_raw_n = '1;
    logic [NS-1:0] sw_raw = '0;
    logic [NK-1:0] keys_n;
    logic [NS-1:0] sw;
    logic          tick;

    bsw_debounce #(.NKEYS(NK), .NSW(NS), .PRESCALE(P), .STABLE(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .keys_raw_n(keys_raw_n),
        .sw_raw    (sw_raw),
        .keys_n    (keys_n),
        .sw        (sw),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: pin level reaches the sample two edges later; a sample that
    // disagrees with the output is accepted on the tick that completes S ticks
    // since the last cycle it agreed. Ticks are edges k with k mod P == P-1.
    logic [NCH-1:0] m_s1, m_s2, m_out;
    int             m_k;
    int             m_agree [NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_edge();
        logic [NCH-1:0] raw;
        logic           tk;
        raw = {sw_raw, keys_raw_n};
        if (!rst_n) begin
            m_s1  = IDLE_V;
            m_s2  = IDLE_V;
            m_out = IDLE_V;
            m_k   = 0;
            for (int i = 0; i < NCH; i++) m_agree[i] = -1;
        end else begin
            tk = (m_k % P == P - 1);
            for (int i = 0; i < NCH; i++) begin
                if (m_s2[i] == m_out[i]) begin
                    m_agree[i] = m_k;
                end else if (tk && ((m_k + 1) / P - (m_agree[i] + 1) / P >= S)) begin
                    m_out[i]   = m_s2[i];
                    m_agree[i] = m_k;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
            m_k++;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("keys_n", 32'(keys_n), 32'(m_out[NK-1:0]));
        chk("sw", 32'(sw), 32'(m_out[NCH-1:NK]));
        chk("tick", 32'(tick), 32'(m_k % P == P - 1));
    endtask

    // Steps until output channel ch shows lvl; lat = 999 if it never does.
    task automatic wait_change(input int ch, input logic lvl, input int maxc, output int lat);
        logic [NCH-1:0] cur;
        lat = 999;
        for (int i = 1; i <= maxc; i++) begin
            step();
            cur = {sw, keys_n};
            if (cur[ch] == lvl) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < 40 && seen < n; i++) begin
            step();
            if (tick) seen++;
        end
        chk("tick_wait", 32'(seen), 32'(n));
    endtask

    initial begin
        int lat, lk, ls, bad, edges;
        logic prev;
        logic [NCH-1:0] r;

        // Reset with every input active.
        keys_raw_n = 4'h0;
        sw_raw     = 8'hFF;
        rst_n      = 1'b0;
        step();
        step();
        chk("rst_keys_n", 32'(keys_n), 32'h0000000F);
        chk("rst_sw", 32'(sw), 32'h00000000);
        chk("rst_tick", 32'(tick), 32'h00000000);
        rst_n = 1'b1;
        lat = 999;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (keys_n == 4'h0 && sw == 8'hFF) begin
                lat = i;
                break;
            end
        end
        chk("rst_release_latency", 32'(lat), 32'd12);

        keys_raw_n = 4'hF;
        sw_raw     = 8'h00;
        for (int i = 0; i < 20; i++) step();

        // Clean press.
        keys_raw_n[0] = 1'b0;
        wait_change(0, 1'b0, 20, lat);
        chk("press_latency_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        for (int i = 0; i < 6; i++) step();

        // Bouncing switch.
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            sw_raw[3] = ((i / 3) % 2 == 0);
            step();
            if (sw[3] != 1'b0) bad++;
        end
        chk("bounce_quiet", 32'(bad), 32'd0);
        sw_raw[3] = 1'b1;
        wait_change(NK + 3, 1'b1, 20, lat);
        chk("bounce_latency_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        edges = 0;
        prev  = sw[3];
        for (int i = 0; i < 20; i++) begin
            step();
            if (sw[3] != prev) edges++;
            prev = sw[3];
        end
        chk("bounce_single_edge", 32'(edges), 32'd0);

        // Simultaneous key and switch change.
        keys_raw_n[2] = 1'b0;
        sw_raw[5]     = 1'b1;
        lk = 999;
        ls = 999;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (lk == 999 && keys_n[2] == 1'b0) lk = i;
            if (ls == 999 && sw[5] == 1'b1) ls = i;
        end
        chk("simul_same_cycle", 32'(lk), 32'(ls));
        chk("simul_latency_ok", 32'(lk >= 11 && lk <= 14), 32'd1);

        // Reset in the middle of a qualification.
        keys_raw_n[1] = 1'b0;
        wait_ticks(2);
        rst_n = 1'b0;
        step();
        chk("midrst_key1", 32'(keys_n[1]), 32'd1);
        rst_n = 1'b1;
        wait_change(1, 1'b0, 20, lat);
        chk("midrst_latency_ok", 32'(lat >= 11 && lat <= 14), 32'd1);
        for (int i = 0; i < 4; i++) step();

        // Release with a one-cycle glitch back to pressed.
        keys_raw_n[0] = 1'b1;
        wait_ticks(2);
        keys_raw_n[0] = 1'b0;
        step();
        keys_raw_n[0] = 1'b1;
        wait_change(0, 1'b1, 20, lat);
        chk("glitch_latency_ok", 32'(lat >= 11 && lat <= 14), 32'd1);

        // Random bouncing at several rates with occasional resets.
        for (int w = 0; w < 30; w++) begin
            int den;
            case ($urandom_range(0, 2))
                0:       den = 2;
                1:       den = 8;
                default: den = 40;
            endcase
            for (int c = 0; c < 50; c++) begin
                r = {sw_raw, keys_raw_n};
                for (int i = 0; i < NCH; i++)
                    if ($urandom_range(0, den - 1) == 0) r[i] = ~r[i];
                {sw_raw, keys_raw_n} = r;
                rst_n = ($urandom_range(0, 199) != 0);
                step();
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
